// File: rtl/csa_accum_pipe.sv
// csa_accum_pipe: pipelined multi-operand carry-save accumulator with a single final carry-propagate resolve
//   clk       : clock, rising edge
//   rst       : asynchronous active-high reset
//   in_valid  : beat present
//   in_ready  : high in ACC; a beat can be accepted
//   in_data   : NOPS unsigned operands, operand k at [k*BW +: BW]
//   in_last   : final beat of the packet, sampled with in_valid
//   out_valid : high in OUT; result presented
//   out_ready : consumer accepts the result
//   out_sum   : packet total modulo 2^ACC_W
//   out_ovf   : packet total >= 2^ACC_W
module csa_accum_pipe #(
    parameter int BW    = 8,
    parameter int NOPS  = 4,
    parameter int ACC_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [NOPS*BW-1:0]   in_data,
    input  logic                 in_last,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ACC_W-1:0]     out_sum,
    output logic                 out_ovf
);
    typedef enum logic [1:0] {ACC = 2'd0, RESOLVE = 2'd1, OUT = 2'd2} state_t;
    state_t r_state, w_next;
    logic [ACC_W-1:0] r_sum, r_carry, r_out_sum;
    logic r_ovf, r_out_ovf;
    logic [ACC_W-1:0] w_s [NOPS+1];
    logic [ACC_W-1:0] w_c [NOPS+1];
    logic [NOPS-1:0] w_drop;
    logic [ACC_W:0] w_total;
    logic w_acc;
    assign w_s[0] = r_sum;
    assign w_c[0] = r_carry;
    // One 3:2 layer per operand folds it into the running redundant pair.
    // The majority bit at ACC_W-1 would carry into weight 2^ACC_W, so it is
    // reported as overflow instead of being silently dropped.
    for (genvar k = 0; k < NOPS; k++) begin : g_csa
        logic [ACC_W-1:0] w_op, w_maj;
        assign w_op      = {{(ACC_W-BW){1'b0}}, in_data[k*BW +: BW]};
        assign w_s[k+1]  = w_s[k] ^ w_c[k] ^ w_op;
        assign w_maj     = (w_s[k] & w_c[k]) | (w_s[k] & w_op) | (w_c[k] & w_op);
        assign w_c[k+1]  = {w_maj[ACC_W-2:0], 1'b0};
        assign w_drop[k] = w_maj[ACC_W-1];
    end
    assign w_total   = {1'b0, r_sum} + {1'b0, r_carry};
    assign in_ready  = r_state == ACC;
    assign out_valid = r_state == OUT;
    assign out_sum   = r_out_sum;
    assign out_ovf   = r_out_ovf;
    assign w_acc     = in_valid && in_ready;
    always_comb begin
        w_next = r_state == ACC     ? (w_acc && in_last ? RESOLVE : ACC) :
                 r_state == RESOLVE ? OUT :
                 out_ready          ? ACC : OUT;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ACC;
            r_sum     <= '0;
            r_carry   <= '0;
            r_ovf     <= 1'b0;
            r_out_sum <= '0;
            r_out_ovf <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_acc) begin
                r_sum   <= w_s[NOPS];
                r_carry <= w_c[NOPS];
                r_ovf   <= r_ovf | (|w_drop);
            end
            if (r_state == RESOLVE) begin
                r_out_sum <= w_total[ACC_W-1:0];
                r_out_ovf <= r_ovf | w_total[ACC_W];
            end
            if (out_valid && out_ready) begin
                r_sum   <= '0;
                r_carry <= '0;
                r_ovf   <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_csa_accum_pipe.sv
// tb_csa_accum_pipe: self-checking bench for csa_accum_pipe
module tb_csa_accum_pipe;
    localparam int BW = 8, NOPS = 4, ACC_W = 16;
    logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b0;
    logic [NOPS*BW-1:0] in_data = '0;
    logic in_ready, out_valid, out_ovf;
    logic [ACC_W-1:0] out_sum;
    int n_checks = 0, n_fail = 0;

    csa_accum_pipe #(.BW(BW), .NOPS(NOPS), .ACC_W(ACC_W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_last(in_last), .out_valid(out_valid),
        .out_ready(out_ready), .out_sum(out_sum), .out_ovf(out_ovf)
    );

    always #5 clk = ~clk;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
        $fatal(1);
    end

    typedef struct {
        logic [31:0] data;
        int          beats;
        int          gap;
        logic [15:0] es;
        logic        eo;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] d, input logic last);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        step();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_valid(input string name);
        int n = 0;
        while (!out_valid && n < 10) begin
            step();
            n++;
        end
        chk({name, "_valid"}, out_valid, 1);
    endtask

    task automatic get_result(input string name, input logic [15:0] es, input logic eo);
        wait_valid(name);
        chk({name, "_sum"}, out_sum, es);
        chk({name, "_ovf"}, out_ovf, eo);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk({name, "_in_ready_after"}, in_ready, 1);
        chk({name, "_valid_drop"}, out_valid, 0);
    endtask

    vec_t tbl[5];
    longint total;
    logic [31:0] d;
    int nb, gap;
    logic hi;

    initial begin
        tbl[0] = '{32'h04030201,  1, 0, 16'd10,    1'b0};
        tbl[1] = '{32'hFFFFFFFF,  3, 2, 16'h0BF4,  1'b0};
        tbl[2] = '{32'hFFFFFFFF, 64, 0, 16'd65280, 1'b0};
        tbl[3] = '{32'hFFFFFFFF, 65, 0, 16'd764,   1'b1};
        tbl[4] = '{32'h00000005,  1, 0, 16'd5,     1'b0};

        #1;
        chk("reset_valid", out_valid, 0);
        chk("reset_in_ready", in_ready, 1);
        chk("reset_sum", out_sum, 0);
        chk("reset_ovf", out_ovf, 0);
        @(negedge clk) rst = 1'b0;
        step();

        // Latency: RESOLVE right after the last-beat edge, OUT one edge later
        send(32'h04030201, 1'b1);
        chk("lat_resolve_valid", out_valid, 0);
        chk("lat_resolve_ready", in_ready, 0);
        step();
        chk("lat_out_valid", out_valid, 1);
        get_result("lat", 16'd10, 1'b0);

        for (int i = 0; i < 5; i++) begin
            for (int b = 0; b < tbl[i].beats; b++) begin
                send(tbl[i].data, b == tbl[i].beats - 1);
                if (b == 0) repeat (tbl[i].gap) step();
            end
            get_result($sformatf("tbl%0d", i), tbl[i].es, tbl[i].eo);
        end

        // Backpressure with junk beats offered while the result is held
        send(32'h04030201, 1'b1);
        wait_valid("bp");
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_data  = $urandom;
            in_last  = 1'($urandom_range(0, 1));
            step();
            chk("bp_hold_sum", out_sum, 16'd10);
            chk("bp_hold_in_ready", in_ready, 0);
            chk("bp_hold_valid", out_valid, 1);
        end
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("bp_release_in_ready", in_ready, 1);
        chk("bp_release_valid", out_valid, 0);
        chk("bp_release_sum_kept", out_sum, 16'd10);
        send(32'h00000005, 1'b1);
        get_result("bp_next", 16'd5, 1'b0);

        // Asynchronous reset while a result is being presented
        send(32'h04030201, 1'b1);
        wait_valid("arst");
        #3;
        rst = 1'b1;
        #1;
        chk("arst_valid", out_valid, 0);
        chk("arst_in_ready", in_ready, 1);
        chk("arst_sum", out_sum, 0);
        chk("arst_ovf", out_ovf, 0);
        @(negedge clk) rst = 1'b0;
        step();

        // Reset discards a partial packet
        send(32'h64646464, 1'b0);
        send(32'h64646464, 1'b0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid_rst_valid", out_valid, 0);
        send(32'h00000001, 1'b1);
        get_result("mid_rst", 16'd1, 1'b0);

        // Random packets against an integer-total model
        for (int p = 0; p < 25; p++) begin
            nb    = $urandom_range(1, 70);
            hi    = 1'($urandom_range(0, 1));
            total = 0;
            for (int b = 0; b < nb; b++) begin
                d = $urandom;
                if (hi) d = d | 32'hC0C0C0C0;
                for (int k = 0; k < NOPS; k++) total += longint'(d[k*BW +: BW]);
                send(d, b == nb - 1);
                gap = $urandom_range(0, 2);
                if (b != nb - 1) begin
                    in_data = $urandom;
                    repeat (gap) step();
                end
            end
            get_result($sformatf("rand%0d", p), total[15:0], total >= 65536);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
